// File: rtl/word_loader_if.sv
// Byte stream, input-SRAM write port and encoder handshake for word_loader.
// master is the upstream/encoder side; slave is the loader itself.
interface word_loader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic                  enc_cs;
  logic                  enc_done;
  logic [ADDR_WIDTH-1:0] len;
  logic                  overflow;
  logic                  word_done;

  modport master (
    output s_valid, s_data, s_last, enc_done,
    input  s_ready, ram_we, ram_addr, ram_din, enc_cs, len, overflow, word_done
  );

  modport slave (
    input  s_valid, s_data, s_last, enc_done,
    output s_ready, ram_we, ram_addr, ram_din, enc_cs, len, overflow, word_done
  );
endinterface

// File: rtl/word_loader.sv
// Loads one word from a byte stream into the encoder input SRAM, appends a
// terminator, starts the encoder and holds off upstream until it finishes.
module word_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TERMINATOR = '0
) (
  input logic clk,
  input logic rst,
  word_loader_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(DEPTH - 2);
  localparam logic [ADDR_WIDTH-1:0] MAX_LEN   = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {LOAD, DRAIN, TERM, START, WAIT, FINISH} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] len_q;
  logic                  overflow_q;
  logic                  ready;
  logic                  accept;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic                  cs;
  logic                  done_pulse;

  assign ready  = ((state == LOAD) || (state == DRAIN)) && !rst;
  assign accept = bus.s_valid && ready;

  // Every strobe is gated by rst so an abandoned word never writes or starts.
  always_comb begin
    state_next = state;
    we         = 1'b0;
    addr       = '0;
    din        = '0;
    cs         = 1'b0;
    done_pulse = 1'b0;
    case (state)
      LOAD: begin
        if (accept) begin
          we   = 1'b1;
          addr = count;
          din  = bus.s_data;
          if (bus.s_last)
            state_next = TERM;
          else if (count == LAST_SLOT)
            state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (accept && bus.s_last)
          state_next = TERM;
      end
      TERM: begin
        we         = !rst;
        addr       = len_q;
        din        = TERMINATOR;
        state_next = START;
      end
      START: begin
        cs         = !rst;
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.enc_done)
          state_next = FINISH;
      end
      FINISH: begin
        done_pulse = !rst;
        state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // count is cleared on leaving LOAD, so count == 0 in LOAD marks the first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      count      <= '0;
      len_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == LOAD) && accept) begin
        if (count == '0)
          overflow_q <= 1'b0;
        if (bus.s_last) begin
          len_q <= count + 1'b1;
          count <= '0;
        end else if (count == LAST_SLOT) begin
          overflow_q <= 1'b1;
          len_q      <= MAX_LEN;
          count      <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  assign bus.s_ready   = ready;
  assign bus.ram_we    = we;
  assign bus.ram_addr  = addr;
  assign bus.ram_din   = din;
  assign bus.enc_cs    = cs;
  assign bus.word_done = done_pulse;
  assign bus.len       = len_q;
  assign bus.overflow  = overflow_q;
endmodule
